// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Purpose  : Execute-stage requester for the iterative divider. It accepts
//            DIV/DIVU from EX and drives the divider start/cancel/operand
//            handshake. It stalls EX until the divider reports ready, then
//            presents {remainder, quotient} as a HI/LO write. A pipeline
//            flush aborts the request. A watchdog substitutes a zero result
//            if div_ready_in never arrives.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            div_op_in            - DIV/DIVU valid in EX
//            signed_op_in         - 1 = DIV, 0 = DIVU
//            reg1_in, reg2_in     - dividend / divisor
//            hold_in, flush_in    - pipeline hold / squash of EX
//            div_res_in           - divider result {remainder, quotient}
//            div_ready_in         - divider result valid (1-cycle pulse)
//            signed_div_out, dived_out, div_out - operands to divider
//            div_start_out        - request, held through BUSY
//            div_cancel_out       - one-cycle abort pulse
//            stall_req_out        - EX stall request
//            hilo_we_out          - HI/LO write enable
//            hi_out, lo_out       - remainder / quotient
//            div_timeout_out      - result is a watchdog substitute
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_op_in,
  input  logic                  signed_op_in,
  input  logic [DATA_W-1:0]     reg1_in,
  input  logic [DATA_W-1:0]     reg2_in,
  input  logic                  hold_in,
  input  logic                  flush_in,
  input  logic [2*DATA_W-1:0]   div_res_in,
  input  logic                  div_ready_in,
  output logic                  signed_div_out,
  output logic [DATA_W-1:0]     dived_out,
  output logic [DATA_W-1:0]     div_out,
  output logic                  div_start_out,
  output logic                  div_cancel_out,
  output logic                  stall_req_out,
  output logic                  hilo_we_out,
  output logic [DATA_W-1:0]     hi_out,
  output logic [DATA_W-1:0]     lo_out,
  output logic                  div_timeout_out
);

  // Watchdog only has to reach TIMEOUT-1 before BUSY is left; one extra
  // count of headroom covers the increment on the exit cycle.
  localparam int                 c_WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_WD_W-1:0]    r_wdog;
  logic                 r_signed;
  logic [DATA_W-1:0]    r_dived;
  logic [DATA_W-1:0]    r_div;
  logic [DATA_W-1:0]    r_hi;
  logic [DATA_W-1:0]    r_lo;
  logic                 r_timeout;

  logic                 w_accept;
  logic                 w_wd_hit;
  logic                 w_start;
  logic                 w_cancel;
  logic                 w_stall;
  logic                 w_we;

  assign w_accept = div_op_in && !flush_in;
  assign w_wd_hit = (r_wdog == c_WD_LAST);

  // --------------------------------------------------------------------------
  // Next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_cancel = 1'b0;
    w_stall  = 1'b0;
    w_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_stall = 1'b1;
          w_next  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush_in) begin
          // Flush wins over ready and timeout; a same-cycle result is dropped.
          w_cancel = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (div_ready_in) begin
            w_start = 1'b1;
            w_next  = S_DONE;
          end else if (w_wd_hit) begin
            w_cancel = 1'b1;
            w_next   = S_DONE;
          end else begin
            w_start = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_we = !flush_in;
        if (flush_in || !hold_in) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, operand, watchdog and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wdog    <= '0;
      r_signed  <= 1'b0;
      r_dived   <= '0;
      r_div     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dived  <= reg1_in;
            r_div    <= reg2_in;
            r_signed <= signed_op_in;
            r_wdog   <= '0;
          end
        end
        S_BUSY: begin
          r_wdog <= r_wdog + c_WD_W'(1);
          if (!flush_in) begin
            if (div_ready_in) begin
              r_hi      <= div_res_in[2*DATA_W-1:DATA_W];
              r_lo      <= div_res_in[DATA_W-1:0];
              r_timeout <= 1'b0;
            end else if (w_wd_hit) begin
              r_hi      <= '0;
              r_lo      <= '0;
              r_timeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign signed_div_out  = r_signed;
  assign dived_out       = r_dived;
  assign div_out         = r_div;
  assign div_start_out   = w_start;
  assign div_cancel_out  = w_cancel;
  assign stall_req_out   = w_stall;
  assign hilo_we_out     = w_we;
  assign hi_out          = r_hi;
  assign lo_out          = r_lo;
  assign div_timeout_out = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Purpose  : Directed self-checking bench for div_ctrl. The main instance
//            uses default parameters; a second instance with TIMEOUT=8
//            exercises the watchdog path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op = 1'b0, sg = 1'b0, hold = 1'b0, flush = 1'b0, ready = 1'b0;
  logic [W-1:0]  r1 = '0, r2 = '0;
  logic [2*W-1:0] res = '0;

  logic          sdiv, start, cancel, stall, we, tmo;
  logic [W-1:0]  dived, divo, hi, lo;

  logic          t_op = 1'b0, t_ready = 1'b0;
  logic          t_sdiv, t_start, t_cancel, t_stall, t_we, t_tmo;
  logic [W-1:0]  t_dived, t_divo, t_hi, t_lo;

  int n_chk = 0;
  int n_err = 0;
  int n_stall = 0;
  int n_we = 0;

  always #5 clk = ~clk;

  div_ctrl #(.DATA_W(W), .TIMEOUT(40)) u_dut (
    .clk(clk), .rst(rst), .div_op_in(op), .signed_op_in(sg),
    .reg1_in(r1), .reg2_in(r2), .hold_in(hold), .flush_in(flush),
    .div_res_in(res), .div_ready_in(ready),
    .signed_div_out(sdiv), .dived_out(dived), .div_out(divo),
    .div_start_out(start), .div_cancel_out(cancel), .stall_req_out(stall),
    .hilo_we_out(we), .hi_out(hi), .lo_out(lo), .div_timeout_out(tmo)
  );

  div_ctrl #(.DATA_W(W), .TIMEOUT(8)) u_dut_to (
    .clk(clk), .rst(rst), .div_op_in(t_op), .signed_op_in(sg),
    .reg1_in(r1), .reg2_in(r2), .hold_in(hold), .flush_in(flush),
    .div_res_in(res), .div_ready_in(t_ready),
    .signed_div_out(t_sdiv), .dived_out(t_dived), .div_out(t_divo),
    .div_start_out(t_start), .div_cancel_out(t_cancel), .stall_req_out(t_stall),
    .hilo_we_out(t_we), .hi_out(t_hi), .lo_out(t_lo), .div_timeout_out(t_tmo)
  );

  // Running totals of stall and write cycles on the main instance.
  always @(negedge clk) begin
    if (stall === 1'b1) n_stall <= n_stall + 1;
    if (we === 1'b1)    n_we    <= n_we + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request on the main instance. lat = BUSY cycle carrying ready
  // (0 = never), fl = BUSY cycle carrying flush (0 = none), hold_n = hold
  // cycles applied in DONE.
  task automatic run_div(input string tag, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int lat, input logic [63:0] rv,
                         input int fl, input int hold_n);
    int s_stall, s_we;
    bit done_ok;
    step;
    op = 1'b1; sg = s; r1 = a; r2 = b; ready = 1'b0; flush = 1'b0; hold = 1'b0; res = rv;
    #1;
    s_stall = n_stall;
    s_we    = n_we;
    chk({tag, ".stall_t0"}, stall, 1);
    done_ok = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step;
      // Scramble the live inputs so only latched operands can match.
      op = 1'b0; sg = ~s; r1 = ~a; r2 = ~b;
      ready = (i == lat); flush = (i == fl);
      #1;
      if (i == 1) begin
        chk({tag, ".start"},  start, 1);
        chk({tag, ".dived"},  dived, a);
        chk({tag, ".div"},    divo,  b);
        chk({tag, ".signed"}, sdiv,  s);
      end
      if (i == fl) begin
        chk({tag, ".cancel"},       cancel, 1);
        chk({tag, ".cancel_start"}, start,  0);
        chk({tag, ".cancel_stall"}, stall,  0);
        #4;
        chk({tag, ".stall_total"}, 64'(n_stall - s_stall), 64'(fl));
        chk({tag, ".we_total"},    64'(n_we - s_we), 0);
        return;
      end
      if (i == lat) begin
        chk({tag, ".dived_end"},  dived,  a);
        chk({tag, ".signed_end"}, sdiv,   s);
        chk({tag, ".start_end"},  start,  1);
        chk({tag, ".no_cancel"},  cancel, 0);
        done_ok = 1'b1;
        break;
      end
    end
    if (!done_ok) begin
      chk({tag, ".busy_bound"}, 0, 1);
      return;
    end
    for (int h = 0; h <= hold_n; h++) begin
      step;
      ready = 1'b0; flush = 1'b0; hold = (h < hold_n);
      #1;
      chk({tag, ".we"},    we,    1);
      chk({tag, ".hi"},    hi,    rv[63:32]);
      chk({tag, ".lo"},    lo,    rv[31:0]);
      chk({tag, ".tmo"},   tmo,   0);
      chk({tag, ".stall"}, stall, 0);
      chk({tag, ".start"}, start, 0);
    end
    #4;
    chk({tag, ".stall_total"}, 64'(n_stall - s_stall), 64'(lat + 1));
    chk({tag, ".we_total"},    64'(n_we - s_we), 64'(hold_n + 1));
    hold = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    step;
    op = 1'b0; ready = 1'b0; flush = 1'b0; hold = 1'b0;
    #1;
    chk({tag, ".idle_we"},    we,    0);
    chk({tag, ".idle_stall"}, stall, 0);
    chk({tag, ".idle_start"}, start, 0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step; step;
    #1;
    chk("rst.start",  start,  0);
    chk("rst.cancel", cancel, 0);
    chk("rst.stall",  stall,  0);
    chk("rst.we",     we,     0);
    chk("rst.hi",     hi,     0);
    chk("rst.lo",     lo,     0);
    chk("rst.tmo",    tmo,    0);
    chk("rst.dived",  dived,  0);
    rst = 1'b0;

    // DIVU 100/7: rem 2, quot 14, ready on 34th BUSY cycle
    run_div("divu", 1'b0, 32'd100, 32'd7, 34, 64'h00000002_0000000E, 0, 0);
    idle_chk("divu");

    // Ready in IDLE is ignored
    step; ready = 1'b1; res = 64'hDEAD_BEEF_CAFE_F00D; #1;
    step; ready = 1'b0; #1;
    chk("ign_ready.we", we, 0);
    chk("ign_ready.hi", hi, 32'd2);
    chk("ign_ready.lo", lo, 32'd14);

    // DIV -7/2: quotient -3, remainder -1
    run_div("div", 1'b1, 32'hFFFF_FFF9, 32'd2, 6, 64'hFFFFFFFF_FFFFFFFD, 0, 0);
    idle_chk("div");

    // Flush at 10th BUSY cycle, then flush coincident with ready
    run_div("flush", 1'b0, 32'd50, 32'd5, 0, 64'h0, 10, 0);
    idle_chk("flush");
    run_div("flush_rdy", 1'b0, 32'd50, 32'd5, 10, 64'h00001234_00005678, 10, 0);
    idle_chk("flush_rdy");
    chk("flush_rdy.hi_kept", hi, 32'hFFFF_FFFF);
    chk("flush_rdy.lo_kept", lo, 32'hFFFF_FFFD);

    // Hold 3 cycles in DONE, then back-to-back DIVU 9/3 from IDLE
    run_div("hold", 1'b0, 32'd1000, 32'd10, 5, 64'h00000000_00000064, 0, 3);
    run_div("b2b", 1'b0, 32'd9, 32'd3, 4, 64'h00000000_00000003, 0, 0);
    idle_chk("b2b");

    // Watchdog instance: normal completion first, so the zero load is visible
    step; t_op = 1'b1; sg = 1'b0; r1 = 32'd20; r2 = 32'd3; res = 64'h00000002_00000006; #1;
    for (int i = 1; i <= 3; i++) begin
      step; t_op = 1'b0; t_ready = (i == 3); #1;
    end
    step; t_ready = 1'b0; #1;
    chk("to_pre.we", t_we, 1);
    chk("to_pre.hi", t_hi, 32'd2);
    chk("to_pre.lo", t_lo, 32'd6);
    step; t_op = 1'b1; #1;
    for (int i = 1; i <= 8; i++) begin
      step; t_op = 1'b0; #1;
      if (i == 7) begin
        chk("to.cancel_early", t_cancel, 0);
        chk("to.start_early",  t_start,  1);
      end
      if (i == 8) begin
        chk("to.cancel", t_cancel, 1);
        chk("to.start",  t_start,  0);
      end
    end
    step; #1;
    chk("to.we",    t_we,    1);
    chk("to.hi",    t_hi,    0);
    chk("to.lo",    t_lo,    0);
    chk("to.tmo",   t_tmo,   1);
    chk("to.stall", t_stall, 0);
    step; #1;
    chk("to.idle_we", t_we, 0);
    step; t_op = 1'b1; r1 = 32'd8; r2 = 32'd2; res = 64'h00000000_00000004; #1;
    for (int i = 1; i <= 2; i++) begin
      step; t_op = 1'b0; t_ready = (i == 2); #1;
    end
    step; t_ready = 1'b0; #1;
    chk("to_post.we",  t_we,  1);
    chk("to_post.tmo", t_tmo, 0);
    chk("to_post.lo",  t_lo,  32'd4);

    // Reset during BUSY
    step; op = 1'b1; sg = 1'b1; r1 = 32'd77; r2 = 32'd7; #1;
    for (int i = 1; i <= 5; i++) begin
      step; op = 1'b0; #1;
    end
    rst = 1'b1;
    step; rst = 1'b0; #1;
    chk("midrst.start",  start,  0);
    chk("midrst.cancel", cancel, 0);
    chk("midrst.stall",  stall,  0);
    chk("midrst.we",     we,     0);
    chk("midrst.lo",     lo,     0);
    chk("midrst.dived",  dived,  0);
    chk("midrst.div",    divo,   0);
    chk("midrst.signed", sdiv,   0);
    run_div("after_rst", 1'b0, 32'd77, 32'd7, 3, 64'h00000000_0000000B, 0, 0);
    idle_chk("after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
